data_mem_bus: RTL

//  Word-organised data RAM for the CPU load/store stage, behind a valid/ready request/response handshake.

---
 rtl/data_mem_bus_if.sv | 24 ++
 rtl/data_mem_bus.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bus_if.sv
// rtl/data_mem_bus_if.sv - request/response handshake bundle for the load/store data RAM
interface data_mem_bus_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_bus.sv
// rtl/data_mem_bus.sv - word-organised data RAM with byte/half/word load/store and wait states
module data_mem_bus #(
    parameter int DEPTH_LOG2  = 5,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    data_mem_bus_if.slave  bus
);

    localparam int         LP_WORDS = 1 << DEPTH_LOG2;
    localparam logic [3:0] LP_WAIT  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Request copy held for the whole operation
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_count;

    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic [31:0] r_mem [0:LP_WORDS-1];

    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_resp_done;
    logic [DEPTH_LOG2-1:0] w_index;
    logic [1:0]            w_lane;
    logic                  w_size_bad;
    logic                  w_misalign;
    logic                  w_out_of_range;
    logic                  w_err;
    logic [31:0]           w_rd_word;
    logic [31:0]           w_shifted;
    logic [31:0]           w_load;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata_rep;
    logic                  w_do_write;

    assign w_accept    = bus.req_valid & w_req_ready;
    assign w_resp_done = r_resp_valid & bus.resp_ready;

    assign w_index = r_addr[DEPTH_LOG2+1:2];
    assign w_lane  = r_addr[1:0];

    // Access checks evaluated against the latched request
    assign w_size_bad     = (r_size == 2'b11);
    assign w_misalign     = ((r_size == 2'b01) && r_addr[0]) ||
                            ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));
    assign w_out_of_range = ((r_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign w_err          = w_size_bad | w_misalign | w_out_of_range;

    assign w_rd_word  = r_mem[w_index];
    assign w_shifted  = w_rd_word >> {w_lane, 3'b000};
    assign w_do_write = (r_state == S_ACCESS) && r_write && !w_err;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (LP_WAIT != 4'd0) begin
                        w_next = S_WAIT;
                    end else begin
                        w_next = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (r_count == 4'd1) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                if (w_resp_done) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Handshake outputs derived from state and response registers
    always_comb begin
        w_req_ready    = (r_state == S_IDLE);
        bus.req_ready  = w_req_ready;
        bus.resp_valid = r_resp_valid;
        bus.resp_rdata = r_resp_rdata;
        bus.resp_err   = r_resp_err;
    end

    // Load result: selected lanes moved to bit 0, then extended
    always_comb begin
        w_load = w_rd_word;
        case (r_size)
            2'b00:   w_load = {{24{~r_unsigned & w_shifted[7]}},  w_shifted[7:0]};
            2'b01:   w_load = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_rd_word;
        endcase
    end

    // Store lane enables and data replicated onto every lane it may land in
    always_comb begin
        w_be        = 4'b0000;
        w_wdata_rep = r_wdata;
        case (r_size)
            2'b00: begin
                w_be        = 4'b0001 << w_lane;
                w_wdata_rep = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{r_wdata[15:0]}};
            end
            2'b10: begin
                w_be        = 4'b1111;
                w_wdata_rep = r_wdata;
            end
            default: begin
                w_be        = 4'b0000;
                w_wdata_rep = r_wdata;
            end
        endcase
    end

    // Request capture and wait-state countdown
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_write    <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_count    <= 4'd0;
        end else begin
            if (w_accept) begin
                r_write    <= bus.req_write;
                r_size     <= bus.req_size;
                r_unsigned <= bus.req_unsigned;
                r_addr     <= bus.req_addr;
                r_wdata    <= bus.req_wdata;
                r_count    <= LP_WAIT;
            end else if (r_state == S_WAIT) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

    // Response registers: loaded on the access edge, held until consumed
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            if (r_state == S_ACCESS) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= w_err;
                r_resp_rdata <= (w_err || r_write) ? 32'd0 : w_load;
            end else if ((r_state == S_RESP) && w_resp_done) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    // Array write; contents survive reset, and reset forces IDLE so nothing commits
    always_ff @(posedge i_clk) begin
        if (w_do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_index][8*b +: 8] <= w_wdata_rep[8*b +: 8];
                end
            end
        end
    end

endmodule
